// File: rtl/attopu_ctrl_if.sv
// attopu_ctrl_if: instruction-memory and datapath control bundle for attopu_ctrl
// imem_*: fetch handshake (req/addr out, ack/data in); rf_*, in1_sel_imm, imm, alu_op:
// datapath controls out; c_flag/z_flag: registered ALU flags in.
interface attopu_ctrl_if;
  logic imem_req;
  logic [11:0] imem_addr;
  logic imem_ack;
  logic [15:0] imem_data;
  logic [2:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic rf_we, in1_sel_imm;
  logic [15:0] imm;
  logic [6:0] alu_op;
  logic c_flag, z_flag;
  modport master (
    output imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_waddr, rf_we, in1_sel_imm, imm, alu_op,
    input imem_ack, imem_data, c_flag, z_flag
  );
  modport slave (
    input imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_waddr, rf_we, in1_sel_imm, imm, alu_op,
    output imem_ack, imem_data, c_flag, z_flag
  );
endinterface

// File: rtl/attopu_ctrl.sv
// attopu_ctrl: multi-cycle fetch/execute controller for the attopu core
// clk/rst: clock and async active-high reset; run/step: free-run level and single-step pulse;
// bus: fetch port and datapath controls; halted/pc/retired: status outputs.
module attopu_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic step,
  attopu_ctrl_if.master bus,
  output logic halted,
  output logic [11:0] pc,
  output logic [15:0] retired
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t state, nxt;
  logic [15:0] ir;
  logic [3:0] op;
  logic ex, fire, taken, wr;
  assign op = ir[15:12];
  assign ex = state == EXEC;
  assign fire = state == FETCH && bus.imem_ack;
  assign taken = op == 4'h3 || (op == 4'h4 && bus.z_flag) || (op == 4'h5 && bus.c_flag);
  assign wr = ex && op < 4'h3;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? ((run || step) ? FETCH : IDLE) :
          state == FETCH ? (bus.imem_ack ? EXEC : FETCH) :
          state == EXEC  ? (op == 4'hf ? HALT : run ? FETCH : IDLE) : HALT;
  // A taken jump is assigned last so it overrides the fetch-time increment.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= 12'h000;
      ir <= 16'h0000;
      retired <= 16'h0000;
    end else begin
      if (fire) begin
        ir <= bus.imem_data;
        pc <= pc + 12'd1;
      end
      if (ex) begin
        retired <= retired + 16'd1;
        if (taken) pc <= ir[11:0];
      end
    end
  always_comb begin
    bus.imem_req = state == FETCH;
    bus.imem_addr = pc;
    halted = state == HALT;
    bus.rf_we = wr;
    bus.rf_waddr = wr ? ir[11:9] : 3'd0;
    bus.rf_raddr1 = ex && op == 4'h0 ? ir[8:6] : ex && op == 4'h1 ? ir[11:9] : 3'd0;
    bus.rf_raddr2 = ex && op == 4'h1 ? ir[8:6] : 3'd0;
    bus.alu_op = {6'd0, ex && op == 4'h1};
    bus.in1_sel_imm = ex && op == 4'h2;
    bus.imm = ex && op == 4'h2 ? {8'h00, ir[7:0]} : 16'h0000;
  end
endmodule

// File: tb/tb_attopu_ctrl.sv
// tb_attopu_ctrl: directed and randomized check of attopu_ctrl against an instruction-level model
module tb_attopu_ctrl;
  logic clk = 0, rst = 0, run = 0, step = 0;
  logic halted;
  logic [11:0] pc;
  logic [15:0] retired;
  attopu_ctrl_if bus();
  attopu_ctrl dut (.clk(clk), .rst(rst), .run(run), .step(step), .bus(bus.master),
                   .halted(halted), .pc(pc), .retired(retired));
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [15:0] mem [4096];
  int ws = 0, wcnt;
  logic pl_en = 0;
  logic [2:0] pl_a = 0;
  logic [15:0] pl_d = 0;
  logic [15:0] rf [8] = '{default: 16'h0};
  logic fc = 0, fz = 0;
  logic [15:0] in1, in2, alu_y;
  logic [16:0] sum;
  assign bus.imem_ack = bus.imem_req && wcnt == ws;
  assign bus.imem_data = mem[bus.imem_addr];
  assign bus.c_flag = fc;
  assign bus.z_flag = fz;
  always @(posedge clk or posedge rst)
    if (rst) wcnt <= 0;
    else wcnt <= (bus.imem_req && !bus.imem_ack) ? wcnt + 1 : 0;
  always_comb begin
    in1 = bus.in1_sel_imm ? bus.imm : rf[bus.rf_raddr1];
    in2 = rf[bus.rf_raddr2];
    sum = {1'b0, in1} + {1'b0, in2};
    alu_y = bus.alu_op == 7'd1 ? sum[15:0] : in1;
  end
  always @(posedge clk) begin
    if (bus.rf_we) rf[bus.rf_waddr] <= alu_y;
    if (bus.alu_op == 7'd1) begin
      fc <= sum[16];
      fz <= sum[15:0] == 16'h0;
    end
    if (pl_en) rf[pl_a] <= pl_d;
  end

  logic [15:0] ref_rf [8] = '{default: 16'h0};
  logic rc = 0, rz = 0, ref_halt = 0, pf = 0, pe = 0, pw = 0;
  logic [11:0] ref_pc = 0;
  logic [15:0] ref_ret = 0, cur = 0;

  task automatic commit(input logic [15:0] w);
    logic [3:0] o;
    logic [2:0] d, s;
    logic [16:0] t;
    o = w[15:12];
    d = w[11:9];
    s = w[8:6];
    t = {1'b0, ref_rf[d]} + {1'b0, ref_rf[s]};
    if (o == 4'h0) ref_rf[d] = ref_rf[s];
    if (o == 4'h1) begin
      ref_rf[d] = t[15:0];
      rc = t[16];
      rz = t[15:0] == 16'h0;
    end
    if (o == 4'h2) ref_rf[d] = {8'h00, w[7:0]};
    if (o == 4'h3 || (o == 4'h4 && rz) || (o == 4'h5 && rc)) ref_pc = w[11:0];
    if (o == 4'hf) ref_halt = 1;
    ref_ret = ref_ret + 16'd1;
  endtask

  always @(negedge clk) begin
    logic [3:0] o;
    logic ex;
    if (rst) begin
      ref_pc = 0;
      ref_ret = 0;
      ref_halt = 0;
      pf = 0;
      pe = 0;
      pw = 0;
    end else begin
      ex = pf;
      if (pf) ref_pc = ref_pc + 12'd1;
      if (pe) commit(cur);
      if (pl_en) ref_rf[pl_a] = pl_d;
      pf = 0;
      pe = 0;
      chk("pc", pc, ref_pc);
      chk("retired", retired, ref_ret);
      chk("halted", halted, ref_halt);
      chk("c_flag", fc, rc);
      chk("z_flag", fz, rz);
      for (int i = 0; i < 8; i++) chk($sformatf("r%0d", i), rf[i], ref_rf[i]);
      o = cur[15:12];
      if (ex) begin
        chk("exec_req", bus.imem_req, 0);
        chk("rf_we", bus.rf_we, o < 4'h3);
        chk("alu_op", bus.alu_op, o == 4'h1);
        chk("in1_sel_imm", bus.in1_sel_imm, o == 4'h2);
        chk("imm", bus.imm, o == 4'h2 ? {8'h00, cur[7:0]} : 16'h0);
        if (o < 4'h3) chk("rf_waddr", bus.rf_waddr, cur[11:9]);
        if (o < 4'h2) chk("rf_raddr1", bus.rf_raddr1, o == 4'h0 ? cur[8:6] : cur[11:9]);
        if (o == 4'h1) chk("rf_raddr2", bus.rf_raddr2, cur[8:6]);
        pe = 1;
      end else begin
        chk("idle_ctl", {bus.rf_we, bus.alu_op, bus.in1_sel_imm, bus.rf_raddr1, bus.rf_raddr2, bus.rf_waddr}, 0);
        chk("idle_imm", bus.imm, 0);
      end
      if (pw) chk("req_held", bus.imem_req, 1);
      if (ref_halt) chk("halt_req", bus.imem_req, 0);
      if (bus.imem_req) chk("imem_addr", bus.imem_addr, ref_pc);
      if (bus.imem_req && bus.imem_ack) begin
        cur = mem[ref_pc];
        pf = 1;
      end
      pw = bus.imem_req && !bus.imem_ack;
    end
  end

  function automatic logic [15:0] ldi(input logic [2:0] d, input logic [7:0] v);
    return {4'h2, d, 1'b0, v};
  endfunction
  function automatic logic [15:0] rr(input logic [3:0] o, input logic [2:0] d, input logic [2:0] s);
    return {o, d, s, 6'd0};
  endfunction
  function automatic logic [15:0] jp(input logic [3:0] o, input logic [11:0] t);
    return {o, t};
  endfunction

  task automatic do_reset;
    run = 0;
    step = 0;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 0;
  endtask
  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    pl_a = a;
    pl_d = d;
    pl_en = 1;
    @(negedge clk);
    #1 pl_en = 0;
  endtask
  task automatic pulse_step;
    step = 1;
    @(negedge clk);
    #1 step = 0;
  endtask
  task automatic go(input int lim, output int n);
    int k;
    k = 0;
    n = 0;
    run = 1;
    while (!bus.imem_req && k < lim) begin
      @(negedge clk);
      k++;
    end
    while (!halted && n < lim) begin
      n++;
      @(negedge clk);
    end
    chk("halt_reached", halted, 1);
    #1 run = 0;
  endtask
  task automatic prog1;
    mem[0] = ldi(3'd1, 8'h05);
    mem[1] = ldi(3'd2, 8'h03);
    mem[2] = rr(4'h1, 3'd1, 3'd2);
    mem[3] = 16'hF000;
  endtask

  initial begin
    int n, k, len;
    logic c0, z0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h6000;
    #1 rst = 1;
    repeat (2) @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    #1;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_we", bus.rf_we, 0);

    prog1();
    go(100, n);
    chk("p1_cycles", n, 8);
    chk("p1_r1", rf[1], 16'h0008);
    chk("p1_r2", rf[2], 16'h0003);
    chk("p1_retired", retired, 4);
    chk("p1_pc", pc, 12'h004);

    do_reset();
    preload(3'd2, 16'hFF01);
    mem[0] = ldi(3'd1, 8'hFF);
    mem[1] = rr(4'h1, 3'd1, 3'd2);
    mem[2] = jp(4'h4, 12'h020);
    mem[12'h020] = jp(4'h5, 12'h030);
    mem[12'h030] = 16'hF000;
    go(200, n);
    chk("cz_pc", pc, 12'h031);
    chk("cz_retired", retired, 5);
    chk("cz_c", fc, 1);
    chk("cz_z", fz, 1);
    chk("cz_r1", rf[1], 16'h0000);

    do_reset();
    preload(3'd4, 16'h0000);
    mem[0] = ldi(3'd3, 8'h01);
    mem[1] = rr(4'h1, 3'd3, 3'd4);
    mem[2] = jp(4'h3, 12'h010);
    mem[12'h010] = jp(4'h4, 12'h100);
    mem[12'h011] = 16'hF000;
    go(200, n);
    chk("nt_pc", pc, 12'h012);
    chk("nt_z", fz, 0);
    chk("nt_retired", retired, 5);

    do_reset();
    ws = 3;
    prog1();
    go(200, n);
    chk("ws_cycles", n, 20);
    chk("ws_r1", rf[1], 16'h0008);
    chk("ws_retired", retired, 4);
    ws = 2;

    do_reset();
    mem[0] = ldi(3'd5, 8'h11);
    mem[1] = ldi(3'd6, 8'h22);
    mem[2] = 16'hF000;
    pulse_step();
    @(negedge clk);
    #1 pulse_step();
    repeat (10) @(negedge clk);
    #1;
    chk("step_retired", retired, 1);
    chk("step_pc", pc, 12'h001);
    chk("step_r5", rf[5], 16'h0011);
    chk("step_idle_req", bus.imem_req, 0);
    ws = 0;

    do_reset();
    mem[0] = jp(4'h3, 12'hFFF);
    mem[12'hFFF] = 16'h6000;
    pulse_step();
    repeat (5) @(negedge clk);
    #1 chk("wrap_pre", pc, 12'hFFF);
    pulse_step();
    repeat (5) @(negedge clk);
    #1;
    chk("wrap_pc", pc, 12'h000);
    chk("wrap_retired", retired, 2);

    do_reset();
    mem[0] = ldi(3'd7, 8'h09);
    mem[1] = rr(4'h1, 3'd7, 3'd7);
    mem[2] = 16'hF000;
    run = 1;
    k = 0;
    while (!(bus.rf_we && bus.alu_op == 7'd1) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ar_found_add", bus.rf_we && bus.alu_op == 7'd1, 1);
    c0 = fc;
    z0 = fz;
    #2 rst = 1;
    run = 0;
    #1;
    chk("ar_we", bus.rf_we, 0);
    chk("ar_alu_op", bus.alu_op, 0);
    chk("ar_req", bus.imem_req, 0);
    chk("ar_pc", pc, 0);
    chk("ar_retired", retired, 0);
    chk("ar_raddr1", bus.rf_raddr1, 0);
    @(negedge clk);
    #1 rst = 0;
    chk("ar_r7", rf[7], 16'h0009);
    chk("ar_c", fc, c0);
    chk("ar_z", fz, z0);

    for (int p = 0; p < 10; p++) begin
      do_reset();
      ws = $urandom_range(0, 2);
      preload(3'($urandom), 16'($urandom));
      len = $urandom_range(8, 24);
      for (int i = 0; i < len - 1; i++)
        case ($urandom_range(0, 7))
          0, 1: mem[i] = ldi(3'($urandom), 8'($urandom));
          2: mem[i] = rr(4'h0, 3'($urandom), 3'($urandom));
          3, 4, 7: mem[i] = rr(4'h1, 3'($urandom), 3'($urandom));
          5: mem[i] = jp(4'($urandom_range(3, 5)), 12'($urandom_range(i + 1, len - 1)));
          default: mem[i] = {4'($urandom_range(6, 14)), 12'($urandom)};
        endcase
      mem[len - 1] = 16'hF000;
      k = 0;
      while (!halted && k < 3000) begin
        @(negedge clk);
        #1;
        run = $urandom_range(0, 7) != 0;
        step = $urandom_range(0, 3) == 0;
        k++;
      end
      run = 0;
      step = 0;
      chk("rand_halt", halted, 1);
      repeat (3) @(negedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
